// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back decode, 32x32 architectural register file, WB forwarding tap, retire counter.
// Optional macro WB_BYPASS_EN: the read ports return the committing value in its write cycle.
module wb_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins_w,
  input  logic [31:0] pc_w,
  input  logic [31:0] alu_result,
  input  logic [31:0] dm_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] retire_count
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] link_addr;
  logic        dec_we;
  logic [4:0]  dec_dest;
  logic [31:0] dec_data;
  logic [31:0] regs [32];
  logic [31:0] retire_q;
  logic        unused_ins;

  // Big-endian byte lane select; offset 0 is the most significant byte.
  function automatic logic [31:0] ext_byte(input logic [31:0] word, input logic [1:0] off,
                                           input logic sgn);
    logic signed [7:0]  b;
    logic signed [31:0] s;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    s = 32'(b);
    return sgn ? s : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [31:0] word, input logic off,
                                           input logic sgn);
    logic signed [15:0] h;
    logic signed [31:0] s;
    h = off ? word[15:0] : word[31:16];
    s = 32'(h);
    return sgn ? s : {16'd0, h};
  endfunction

  assign op         = ins_w[31:26];
  assign funct      = ins_w[5:0];
  assign rt         = ins_w[20:16];
  assign rd         = ins_w[15:11];
  assign link_addr  = pc_w + 32'd8;
  assign unused_ins = ^{ins_w[25:21], ins_w[10:6]};

  always_comb begin
    dec_we   = 1'b0;
    dec_dest = rt;
    dec_data = alu_result;
    case (op)
      6'h00: begin
        dec_we   = (funct != 6'h08);
        dec_dest = rd;
        dec_data = (funct == 6'h09) ? link_addr : alu_result;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: dec_we = 1'b1;
      6'h03: begin
        dec_we   = 1'b1;
        dec_dest = 5'd31;
        dec_data = link_addr;
      end
      6'h23: begin
        dec_we   = 1'b1;
        dec_data = dm_data;
      end
      6'h20: begin
        dec_we   = 1'b1;
        dec_data = ext_byte(dm_data, alu_result[1:0], 1'b1);
      end
      6'h24: begin
        dec_we   = 1'b1;
        dec_data = ext_byte(dm_data, alu_result[1:0], 1'b0);
      end
      6'h21: begin
        dec_we   = 1'b1;
        dec_data = ext_half(dm_data, alu_result[1], 1'b1);
      end
      6'h25: begin
        dec_we   = 1'b1;
        dec_data = ext_half(dm_data, alu_result[1], 1'b0);
      end
      default: dec_we = 1'b0;
    endcase
  end

  // $0 is never written, so the stored copy stays zero and the tap reports no write.
  assign wb_we   = dec_we && (dec_dest != 5'd0) && !reset;
  assign wb_addr = wb_we ? dec_dest : 5'd0;
  assign wb_data = wb_we ? dec_data : 32'd0;

`ifdef WB_BYPASS_EN
  assign rs_data = (rs_addr == 5'd0) ? 32'd0 :
                   (wb_we && (wb_addr == rs_addr)) ? wb_data : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 :
                   (wb_we && (wb_addr == rt_addr)) ? wb_data : regs[rt_addr];
`else
  assign rs_data = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= 32'd0;
    end else if (ins_w != 32'd0) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic against a reference model.
// Expectations for same-cycle reads follow WB_BYPASS_EN as compiled.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins_w, pc_w, alu_result, dm_data;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data, retire_count;
  logic        wb_we;
  logic [4:0]  wb_addr;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .ins_w(ins_w), .pc_w(pc_w), .alu_result(alu_result),
    .dm_data(dm_data), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
    .rt_data(rt_data), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_count(retire_count)
  );

  // Reference: what the instruction architecturally writes, from the ISA rules.
  task automatic model_decode(input logic [31:0] ins, pc, alu, dm, input logic rst,
                              output logic we, output logic [4:0] a, output logic [31:0] d);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] b, h;
    op = ins[31:26];
    fn = ins[5:0];
    b  = (dm >> (8 * (3 - alu[1:0]))) & 32'hFF;
    h  = (dm >> (16 * (1 - alu[1]))) & 32'hFFFF;
    we = 1'b0; a = 5'd0; d = 32'd0;
    if (op == 6'h00 && fn != 6'h08) begin
      we = 1'b1; a = ins[15:11]; d = (fn == 6'h09) ? pc + 8 : alu;
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      we = 1'b1; a = ins[20:16]; d = alu;
    end else if (op == 6'h03) begin
      we = 1'b1; a = 5'd31; d = pc + 8;
    end else if (op == 6'h23) begin
      we = 1'b1; a = ins[20:16]; d = dm;
    end else if (op == 6'h20 || op == 6'h24) begin
      we = 1'b1; a = ins[20:16];
      d = (op == 6'h20 && b >= 128) ? b + 32'hFFFFFF00 : b;
    end else if (op == 6'h21 || op == 6'h25) begin
      we = 1'b1; a = ins[20:16];
      d = (op == 6'h21 && h >= 32768) ? h + 32'hFFFF0000 : h;
    end
    if (!we || rst || a == 5'd0) begin
      we = 1'b0; a = 5'd0; d = 32'd0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return m_regs[ra];
  endfunction

  task automatic apply(input logic [31:0] ins, pc, alu, dm, input logic [4:0] ra, rb,
                       input logic rst);
    @(negedge clk);
    ins_w = ins; pc_w = pc; alu_result = alu; dm_data = dm;
    rs_addr = ra; rt_addr = rb; reset = rst;
  endtask

  task automatic tick();
    logic we;
    logic [4:0] a;
    logic [31:0] d;
    logic [31:0] ins;
    logic rst;
    model_decode(ins_w, pc_w, alu_result, dm_data, reset, we, a, d);
    ins = ins_w;
    rst = reset;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
    end else begin
      if (we) m_regs[a] = d;
      if (ins != 32'd0) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    apply(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_tap got we=%b addr=%0d data=%h want 0/0/0", wb_we, wb_addr, wb_data);
    end
    tick();
    tick();
    apply(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (retire_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_count got=%h want=0", retire_count);
    end
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      #1;
      checks++;
      if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_reg%0d got rs=%h rt=%h want 0", i, rs_data, rt_data);
      end
    end
  endtask

  task automatic test_rtype();
    apply(32'h01094020, 32'h00400000, 32'h12345678, 32'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (wb_we !== 1'b1 || wb_addr !== 5'd8 || wb_data !== 32'h12345678) begin
      failures++;
      $display("FAIL add_tap got we=%b addr=%0d data=%h want 1/8/12345678", wb_we, wb_addr, wb_data);
    end
    tick();
    apply(32'd0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd8, 1'b0);
    #1;
    checks++;
    if (rs_data !== 32'h12345678 || rt_data !== 32'h12345678 || retire_count !== 32'd1) begin
      failures++;
      $display("FAIL add_commit got rs=%h rt=%h cnt=%h want 12345678/12345678/1",
               rs_data, rt_data, retire_count);
    end
    apply(32'h01090020, 32'h00400004, 32'hDEADBEEF, 32'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0) begin
      failures++;
      $display("FAIL zero_dest_tap got we=%b addr=%0d data=%h want 0/0/0", wb_we, wb_addr, wb_data);
    end
    tick();
    apply(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (rs_data !== 32'd0 || retire_count !== 32'd2) begin
      failures++;
      $display("FAIL zero_dest_commit got r0=%h cnt=%h want 0/2", rs_data, retire_count);
    end
  endtask

  task automatic test_loads();
    logic [31:0] ins_t [4] = '{32'h80040000, 32'h90050000, 32'h84060000, 32'h8C070000};
    logic [31:0] alu_t [4] = '{32'h1000, 32'h1001, 32'h1002, 32'h1000};
    logic [31:0] exp_t [4] = '{32'hFFFFFF80, 32'h000000FF, 32'h00007F01, 32'h80FF7F01};
    for (int i = 0; i < 4; i++) begin
      apply(ins_t[i], 32'h00400100, alu_t[i], 32'h80FF7F01, 5'd0, 5'd0, 1'b0);
      #1;
      checks++;
      if (wb_we !== 1'b1 || wb_addr !== 5'(4 + i) || wb_data !== exp_t[i]) begin
        failures++;
        $display("FAIL load%0d_tap got we=%b addr=%0d data=%h want 1/%0d/%h",
                 i, wb_we, wb_addr, wb_data, 4 + i, exp_t[i]);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      apply(32'd0, 32'd0, 32'd0, 32'd0, 5'(4 + i), 5'(4 + i), 1'b0);
      #1;
      checks++;
      if (rs_data !== exp_t[i] || rt_data !== exp_t[i]) begin
        failures++;
        $display("FAIL load%0d_reg got rs=%h rt=%h want %h", i, rs_data, rt_data, exp_t[i]);
      end
    end
  endtask

  task automatic test_link();
    apply(32'h0C000004, 32'h00400010, 32'h55555555, 32'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (wb_we !== 1'b1 || wb_addr !== 5'd31 || wb_data !== 32'h00400018) begin
      failures++;
      $display("FAIL jal_tap got we=%b addr=%0d data=%h want 1/31/00400018", wb_we, wb_addr, wb_data);
    end
    tick();
    apply(32'h03E00008, 32'h00400018, 32'h00400018, 32'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (wb_we !== 1'b0) begin
      failures++;
      $display("FAIL jr_tap got we=%b want 0", wb_we);
    end
    tick();
    apply(32'd0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd0, 1'b0);
    #1;
    checks++;
    if (rs_data !== 32'h00400018 || retire_count !== m_cnt) begin
      failures++;
      $display("FAIL link_commit got r31=%h cnt=%h want 00400018/%h", rs_data, retire_count, m_cnt);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] exp_same;
    apply(32'h20050000, 32'd0, 32'h11111111, 32'd0, 5'd0, 5'd0, 1'b0);
    tick();
    apply(32'h20050000, 32'd0, 32'hCAFEBABE, 32'd0, 5'd5, 5'd0, 1'b0);
`ifdef WB_BYPASS_EN
    exp_same = 32'hCAFEBABE;
`else
    exp_same = 32'h11111111;
`endif
    #1;
    checks++;
    if (rs_data !== exp_same) begin
      failures++;
      $display("FAIL hazard_same_cycle got=%h want=%h", rs_data, exp_same);
    end
    tick();
    apply(32'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd5, 1'b0);
    #1;
    checks++;
    if (rs_data !== 32'hCAFEBABE || rt_data !== 32'hCAFEBABE) begin
      failures++;
      $display("FAIL hazard_next_cycle got rs=%h rt=%h want CAFEBABE", rs_data, rt_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [5:0] op;
    logic we;
    logic [4:0] a, ra, rb;
    logic [31:0] d, pc, alu, dm;
    logic rst;
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 13))
        0, 1: op = 6'h00;
        2:  op = 6'(8 + $urandom_range(0, 7));
        3:  op = 6'h03;
        4:  op = 6'h23;
        5:  op = 6'h20;
        6:  op = 6'h24;
        7:  op = 6'h21;
        8:  op = 6'h25;
        9:  op = 6'h2B;
        10: op = 6'h04;
        11: op = 6'h02;
        default: op = 6'h3F;
      endcase
      ins[31:26] = op;
      if (op == 6'h00) begin
        case ($urandom_range(0, 3))
          0: ins[5:0] = 6'h08;
          1: ins[5:0] = 6'h09;
          2: ins[5:0] = 6'h2A;
          default: ins[5:0] = 6'h20;
        endcase
      end
      if ($urandom_range(0, 9) == 0) ins = 32'd0;
      pc  = $urandom & 32'hFFFFFFFC;
      alu = $urandom;
      dm  = $urandom;
      ra  = 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 29) == 0);
      apply(ins, pc, alu, dm, ra, rb, rst);
      model_decode(ins, pc, alu, dm, rst, we, a, d);
      #1;
      checks++;
      if (wb_we !== we || wb_addr !== a || wb_data !== d) begin
        failures++;
        $display("FAIL rand%0d_tap ins=%h got %b/%0d/%h want %b/%0d/%h",
                 n, ins, wb_we, wb_addr, wb_data, we, a, d);
      end
      checks++;
      if (rs_data !== model_read(ra, we, a, d) || rt_data !== model_read(rb, we, a, d)) begin
        failures++;
        $display("FAIL rand%0d_read ra=%0d rb=%0d got %h/%h want %h/%h", n, ra, rb,
                 rs_data, rt_data, model_read(ra, we, a, d), model_read(rb, we, a, d));
      end
      tick();
      checks++;
      if (retire_count !== m_cnt) begin
        failures++;
        $display("FAIL rand%0d_count got=%h want=%h", n, retire_count, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    apply(32'h8C030000, 32'd0, 32'h2000, 32'h0BADF00D, 5'd0, 5'd0, 1'b0);
    tick();
    apply(32'h8C030000, 32'd0, 32'h2000, 32'h12121212, 5'd3, 5'd0, 1'b1);
    #1;
    checks++;
    if (wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_write_tap got we=%b addr=%0d data=%h want 0/0/0", wb_we, wb_addr, wb_data);
    end
    tick();
    apply(32'd0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3, 1'b0);
    #1;
    checks++;
    if (rs_data !== 32'd0 || retire_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_write_commit got r3=%h cnt=%h want 0/0", rs_data, retire_count);
    end
  endtask

  task automatic test_wrap();
    apply(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    force dut.retire_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_q;
    m_cnt = 32'hFFFFFFFF;
    #1;
    checks++;
    if (retire_count !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL wrap_preload got=%h want=FFFFFFFF", retire_count);
    end
    apply(32'h03E00008, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if (retire_count !== 32'd0 || retire_count !== m_cnt) begin
      failures++;
      $display("FAIL wrap_count got=%h want=0", retire_count);
    end
  endtask

  initial begin
    reset = 1'b1; ins_w = '0; pc_w = '0; alu_result = '0; dm_data = '0;
    rs_addr = '0; rt_addr = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
    test_reset();
    test_rtype();
    test_loads();
    test_link();
    test_hazard();
    test_random();
    test_reset_mid_write();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs (instruction, PC, ALU result, memory data), decodes the destination and write source, and commits the result into a 32×32 register file. Provides two combinational read ports to decode, a write-back forwarding tap to the hazard/forward unit, and a retired-instruction counter.

## Interface
Parameters:
- none; the architecture fixes the widths at 32 data bits, 32 registers and 5-bit addresses.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ins_w  input  32  instruction in WB; 0 = bubble/nop.
- pc_w  input  32  PC of the WB instruction.
- alu_result  input  32  ALU result; also the load byte address.
- dm_data  input  32  word read from data memory.
- rs_addr  input  5  read port A address, from decode.
- rt_addr  input  5  read port B address, from decode.
- rs_data  output  32  read port A data.
- rt_data  output  32  read port B data.
- wb_we  output  1  a register write commits at the next edge.
- wb_addr  output  5  destination register; 0 when wb_we = 0.
- wb_data  output  32  write value; 0 when wb_we = 0.
- retire_count  output  32  count of retired non-bubble instructions.

## Operation
- Decode uses op = ins_w[31:26], funct = ins_w[5:0], rt = ins_w[20:16] and rd = ins_w[15:11].
- Write selection:
  - op 0x00, funct ≠ 0x08/0x09: rd ← alu_result.
  - op 0x00, funct 0x09 (jalr): rd ← pc_w + 8.
  - op 0x00, funct 0x08 (jr): no write.
  - op 0x08–0x0F (addi…lui): rt ← alu_result.
  - op 0x03 (jal): $31 ← pc_w + 8.
  - op 0x23 (lw): rt ← dm_data.
  - op 0x20 lb, 0x24 lbu: select byte alu_result[1:0] of dm_data, big-endian (offset 0 = bits 31:24). lb sign-extends; lbu zero-extends.
  - op 0x21 lh, 0x25 lhu: select halfword alu_result[1] (0 = bits 31:16). lh sign-extends; lhu zero-extends.
  - All other opcodes, including stores and branches: no write.
- wb_we = decoded-write AND dest ≠ 0 AND NOT reset. Writes to $0 are dropped, and $0 always reads 0.
- Register file: 32 × 32 bits. Writes occur on the clk edge when wb_we = 1. Reads are combinational by address.
- retire_count increments by 1 on each edge where ins_w ≠ 0 and reset = 0. It wraps 0xFFFFFFFF → 0.
- Reset: all 32 registers and retire_count go to 0 at the edge. Reset overrides any concurrent write or increment.

## Timing
- Commit latency: the write lands at the first clk edge after ins_w presents the instruction. With the bypass compiled out, a read of that register returns the new value from the following cycle onward.
- Outputs rs_data, rt_data, wb_we, wb_addr and wb_data are combinational, with no registered delay.
- Reset values, during and after a reset edge with ins_w = 0:
  - rs_data = rt_data = 0;
  - wb_we = 0, wb_addr = 0, wb_data = 0;
  - retire_count = 0.
- Simultaneous read and write of the same nonzero register in one cycle: behaviour depends on Configuration.
- The same register on both read ports returns identical data.

## Configuration
- Macro WB_BYPASS_EN.
- Defined: when wb_we = 1 and rs_addr (or rt_addr) = wb_addr, the read port returns wb_data in the same cycle (write-before-read). Decode needs no stall for a WB→ID hazard.
- Undefined: read ports return only stored register contents, so the old value is seen during the write cycle. The hazard unit must stall or forward externally.

## Test plan
- Reset then idle: assert reset for 2 cycles with ins_w = 0 -> every register reads 0, wb_we = 0, retire_count = 0.
- R-type and $0 guard:
  - ins_w = 0x01094020 (add $8,$8,$9), alu_result = 0x12345678 -> after the edge $8 reads 0x12345678; retire_count = 1.
  - ins_w with rd = 0 -> wb_we = 0, $0 stays 0.
- Loads: dm_data = 0x80FF7F01.
  - lb with alu_result[1:0] = 0 -> 0xFFFFFF80.
  - lbu with offset 1 -> 0x000000FF.
  - lh with alu_result[1] = 1 -> 0x00007F01.
  - lw -> 0x80FF7F01.
- Link: jal with pc_w = 0x00400010 -> $31 = 0x00400018. jr -> no write; retire_count still increments.
- Same-cycle hazard: write $5 ← 0xCAFEBABE while rs_addr = 5 -> rs_data = 0xCAFEBABE with WB_BYPASS_EN defined, old $5 without it. On the next cycle rs_data = 0xCAFEBABE in both builds.
- Reset mid-write and wrap:
  - reset asserted on the same edge as lw $3 -> $3 = 0 and retire_count = 0.
  - Preload counter 0xFFFFFFFF (via 2^32−1 retirements or force) plus one retirement -> retire_count = 0.
